mem_bus_ctrl: RTL and testbench



---
 rtl/mem_bus_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: decodes master address into one-hot slave strobes,
// inserts per-region wait states and registers muxed read data.
module mem_bus_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int N_REGIONS = 4,
  parameter int SEL_W     = 4,
  parameter logic [N_REGIONS*SEL_W-1:0] REGION_IDS =
    {4'h3, 4'h2, 4'h1, 4'h0},
  parameter int WAIT_W    = 4,
  parameter logic [N_REGIONS*WAIT_W-1:0] REGION_WAIT =
    {4'd1, 4'd1, 4'd1, 4'd1},
  parameter logic [DATA_W-1:0] ERR_DATA = '1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mst_en,
  input  logic                        mst_we,
  input  logic [ADDR_W-1:0]           mst_addr,
  input  logic [DATA_W-1:0]           mst_wdata,
  output logic [DATA_W-1:0]           mst_rdata,
  output logic                        mst_ready,
  output logic                        mst_err,
  output logic [N_REGIONS-1:0]        slv_ce,
  output logic [N_REGIONS-1:0]        slv_oce,
  output logic [N_REGIONS-1:0]        slv_we,
  output logic [ADDR_W-SEL_W-1:0]     slv_addr,
  output logic [DATA_W-1:0]           slv_wdata,
  input  logic [N_REGIONS*DATA_W-1:0] slv_rdata
);

  localparam int SA_W = ADDR_W - SEL_W;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERR
  } state_e;

  state_e               state_q, state_d;
  logic [WAIT_W-1:0]    cnt_q, cnt_d;
  logic [N_REGIONS-1:0] sel_q, sel_d;
  logic                 we_q, we_d;
  logic [SA_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;

  logic [N_REGIONS-1:0] hit_oh;
  logic [WAIT_W-1:0]    hit_wait;
  logic                 hit;
  logic [DATA_W-1:0]    rd_mux;

  // Scan high to low so the lowest matching region overrides the rest.
  always_comb begin
    hit_oh   = '0;
    hit_wait = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (mst_addr[ADDR_W-1 -: SEL_W] ==
          REGION_IDS[i*SEL_W +: SEL_W]) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        hit_wait  = REGION_WAIT[i*WAIT_W +: WAIT_W];
      end
    end
  end

  assign hit = |hit_oh;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (sel_q[i]) rd_mux = rd_mux | slv_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (mst_en) begin
          we_d    = mst_we;
          addr_d  = mst_addr[SA_W-1:0];
          wdata_d = mst_wdata;
          sel_d   = hit_oh;
          if (hit) begin
            cnt_d   = hit_wait;
            state_d = ACCESS;
          end else begin
            state_d = ERR;
            if (!mst_we) rdata_d = ERR_DATA;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
          if (!we_q) rdata_d = rd_mux;
        end
      end
      DONE, ERR: begin
        if (!mst_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign slv_ce    = (state_q == ACCESS) ? sel_q : '0;
  assign slv_oce   = slv_ce & {N_REGIONS{~we_q}};
  assign slv_we    = slv_ce & {N_REGIONS{we_q}};
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;
  assign mst_rdata = rdata_q;
  assign mst_ready = (state_q == DONE) || (state_q == ERR);
  assign mst_err   = (state_q == ERR);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed plan items plus random accesses
// checked against a cycle-count model of decode, wait states and read data.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mst_en;
  logic        mst_we;
  logic [15:0] mst_addr;
  logic [15:0] mst_wdata;
  logic [63:0] slv_rdata;

  logic [15:0] mst_rdata;
  logic        mst_ready;
  logic        mst_err;
  logic [3:0]  slv_ce;
  logic [3:0]  slv_oce;
  logic [3:0]  slv_we;
  logic [11:0] slv_addr;
  logic [15:0] slv_wdata;

  logic [15:0] d2_rdata;
  logic        d2_ready;
  logic        d2_err;
  logic [3:0]  d2_ce;
  logic [3:0]  d2_oce;
  logic [3:0]  d2_we;
  logic [11:0] d2_addr;
  logic [15:0] d2_wdata;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_rd;
  int waits[4] = '{1, 3, 0, 15};

  always #5 clk = ~clk;

  mem_bus_ctrl #(
    .REGION_WAIT({4'd15, 4'd0, 4'd3, 4'd1})
  ) dut (
    .clk(clk), .reset(reset),
    .mst_en(mst_en), .mst_we(mst_we),
    .mst_addr(mst_addr), .mst_wdata(mst_wdata),
    .mst_rdata(mst_rdata), .mst_ready(mst_ready),
    .mst_err(mst_err), .slv_ce(slv_ce),
    .slv_oce(slv_oce), .slv_we(slv_we),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata)
  );

  mem_bus_ctrl #(
    .REGION_IDS({4'h3, 4'h0, 4'h1, 4'h0})
  ) dut2 (
    .clk(clk), .reset(reset),
    .mst_en(mst_en), .mst_we(mst_we),
    .mst_addr(mst_addr), .mst_wdata(mst_wdata),
    .mst_rdata(d2_rdata), .mst_ready(d2_ready),
    .mst_err(d2_err), .slv_ce(d2_ce),
    .slv_oce(d2_oce), .slv_we(d2_we),
    .slv_addr(d2_addr), .slv_wdata(d2_wdata),
    .slv_rdata(slv_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int region_of(input logic [15:0] a);
    int r = -1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] id = i[3:0];
      if (r < 0 && a[15:12] == id) r = i;
    end
    return r;
  endfunction

  task automatic access(input logic [15:0] a, input logic w,
                        input logic [15:0] wd, input bit drop);
    int r;
    int wt;
    logic [3:0] oh;
    r = region_of(a);
    @(negedge clk);
    mst_en = 1'b1;
    mst_addr = a;
    mst_we = w;
    mst_wdata = wd;
    if (r < 0) begin
      @(negedge clk);
      chk("err_ce", {28'd0, slv_ce}, 32'd0);
      chk("err_ready", {31'd0, mst_ready}, 32'd1);
      chk("err_flag", {31'd0, mst_err}, 32'd1);
      if (!w) exp_rd = 16'hFFFF;
      chk("err_rdata", {16'd0, mst_rdata}, {16'd0, exp_rd});
      @(negedge clk);
      chk("err_hold", {30'd0, mst_ready, mst_err}, 32'd3);
      mst_en = 1'b0;
      @(negedge clk);
      chk("err_clear", {30'd0, mst_ready, mst_err}, 32'd0);
    end else begin
      wt = waits[r];
      oh = 4'b0001 << r;
      for (int k = 0; k <= wt; k++) begin
        @(negedge clk);
        chk("acc_ce", {28'd0, slv_ce}, {28'd0, oh});
        chk("acc_we", {28'd0, slv_we}, {28'd0, w ? oh : 4'd0});
        chk("acc_oce", {28'd0, slv_oce}, {28'd0, w ? 4'd0 : oh});
        chk("acc_addr", {20'd0, slv_addr}, {20'd0, a[11:0]});
        chk("acc_wdata", {16'd0, slv_wdata}, {16'd0, wd});
        chk("acc_ready", {30'd0, mst_ready, mst_err}, 32'd0);
        if (k == 0 && a[15:12] == 4'h0)
          chk("overlap_ce", {28'd0, d2_ce}, 32'd1);
        mst_addr = 16'($urandom);
        mst_wdata = 16'($urandom);
        if (drop) mst_en = 1'b0;
      end
      @(negedge clk);
      chk("done_ce", {28'd0, slv_ce}, 32'd0);
      chk("done_ready", {30'd0, mst_ready, mst_err}, 32'd2);
      if (!w) exp_rd = slv_rdata[r*16 +: 16];
      chk("done_rdata", {16'd0, mst_rdata}, {16'd0, exp_rd});
      if (!drop) begin
        @(negedge clk);
        chk("done_hold", {31'd0, mst_ready}, 32'd1);
        mst_en = 1'b0;
      end
      @(negedge clk);
      chk("idle_ready", {30'd0, mst_ready, mst_err}, 32'd0);
      chk("idle_ce", {28'd0, slv_ce}, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [3:0]  top;
    reset = 1'b1;
    mst_en = 1'b0;
    mst_we = 1'b0;
    mst_addr = '0;
    mst_wdata = '0;
    slv_rdata = '0;
    exp_rd = '0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {30'd0, mst_ready, mst_err}, 32'd0);
    chk("rst_strobes", {20'd0, slv_ce, slv_oce, slv_we}, 32'd0);
    chk("rst_rdata", {16'd0, mst_rdata}, 32'd0);
    chk("rst_laddr", {20'd0, slv_addr}, 32'd0);
    chk("rst_lwdata", {16'd0, slv_wdata}, 32'd0);
    reset = 1'b0;

    // Reset in the second ACCESS cycle of a W=3 read.
    slv_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mst_en = 1'b1;
    mst_we = 1'b0;
    mst_addr = 16'h1200;
    @(negedge clk);
    chk("mid_ce1", {28'd0, slv_ce}, 32'd2);
    @(negedge clk);
    chk("mid_ce2", {28'd0, slv_ce}, 32'd2);
    reset = 1'b1;
    mst_en = 1'b0;
    @(negedge clk);
    chk("mid_rst_strb", {20'd0, slv_ce, slv_oce, slv_we}, 32'd0);
    chk("mid_rst_rdy", {30'd0, mst_ready, mst_err}, 32'd0);
    chk("mid_rst_rd", {16'd0, mst_rdata}, 32'd0);
    reset = 1'b0;
    access(16'h1200, 1'b0, 16'h0, 1'b0);

    slv_rdata = {48'h0123_4567_89AB, 16'hBEEF};
    access(16'h0123, 1'b0, 16'h0, 1'b0);
    chk("plan_read", {16'd0, mst_rdata}, 32'h0000BEEF);
    access(16'h1045, 1'b1, 16'h5A5A, 1'b0);
    chk("plan_wr_keep", {16'd0, mst_rdata}, 32'h0000BEEF);
    access(16'hF000, 1'b0, 16'h0, 1'b0);
    chk("plan_unmap", {16'd0, mst_rdata}, 32'h0000FFFF);

    // Back-to-back: en held high through DONE must not restart.
    slv_rdata = 64'hAAAA_BBBB_CCCC_D00D;
    @(negedge clk);
    mst_en = 1'b1;
    mst_we = 1'b0;
    mst_addr = 16'h0050;
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("b2b_ready", {31'd0, mst_ready}, 32'd1);
    chk("b2b_rdata", {16'd0, mst_rdata}, 32'h0000D00D);
    exp_rd = 16'hD00D;
    mst_addr = 16'h1077;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b2b_noce", {28'd0, slv_ce}, 32'd0);
      chk("b2b_hold", {31'd0, mst_ready}, 32'd1);
    end
    mst_en = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {31'd0, mst_ready}, 32'd0);
    access(16'h1077, 1'b0, 16'h0, 1'b0);

    access(16'h3ABC, 1'b0, 16'h0, 1'b0);
    access(16'h2001, 1'b0, 16'h0, 1'b1);

    for (int n = 0; n < 24; n++) begin
      slv_rdata = {$urandom, $urandom};
      top = 4'($urandom_range(0, 5));
      ra = {top, 12'($urandom)};
      access(ra, 1'($urandom), 16'($urandom),
             $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
